hwpe_stream_addressgen_v3: RTL and testbench

Three-level strided address generator for HWPE streamers, extending the two-level generator. It walks a word/line/block loop nest with signed strides and runs on a configurable bus width. Misalignment is evaluated per row, so misaligned rows get one extra beat plus byte strobes. It emits word-aligned addresses on a valid/ready stream toward the TCDM request side, driven by a start/busy/done FSM.

---
 rtl/hwpe_stream_addressgen_v3.sv | 179 +++++++++++++++++
 tb/tb_hwpe_stream_addressgen_v3.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_addressgen_v3.sv
// rtl/hwpe_stream_addressgen_v3.sv - three-level strided address generator with per-row misalignment strobes
module hwpe_stream_addressgen_v3 #(
    parameter int unsigned AW       = 32,
    parameter int unsigned NB_BYTES = 4,
    parameter int unsigned CNT      = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [AW-1:0]       base_addr_i,
    input  logic [AW-1:0]       d0_stride_i,
    input  logic [CNT-1:0]      d0_len_i,
    input  logic [AW-1:0]       d1_stride_i,
    input  logic [CNT-1:0]      d1_len_i,
    input  logic [AW-1:0]       d2_stride_i,
    input  logic [CNT-1:0]      d2_len_i,
    output logic                addr_valid_o,
    input  logic                addr_ready_i,
    output logic [AW-1:0]       addr_o,
    output logic [NB_BYTES-1:0] strb_o,
    output logic                first_o,
    output logic                last_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned OB = $clog2(NB_BYTES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT:0]   K_ONE   = {{CNT{1'b0}}, 1'b1};
    localparam logic [CNT-1:0] CNT_ONE = {{(CNT-1){1'b0}}, 1'b1};

    logic [1:0]     state_q;
    logic [AW-1:0]  base_q, d0_stride_q, d1_stride_q, d2_stride_q;
    logic [CNT-1:0] d0_len_q, d1_len_q, d2_len_q;
    logic [CNT:0]   k_q;
    logic [CNT-1:0] d1_cnt_q, d2_cnt_q;
    logic [AW-1:0]  d0_acc_q, d1_acc_q, d2_acc_q;

    logic                running;
    logic                hs;
    logic [AW-1:0]       row_addr;
    logic [OB-1:0]       off;
    logic                misal;
    logic [CNT:0]        beats_m1;
    logic                row_first;
    logic                row_last;
    logic                d1_wrap;
    logic                d2_wrap;
    logic [NB_BYTES-1:0] ones;
    logic [NB_BYTES-1:0] head_strb;
    logic [NB_BYTES-1:0] strb;

    assign running  = (state_q == RUN);
    assign hs       = running & addr_ready_i;

    // Row start is rebuilt from the outer accumulators so the offset is re-evaluated every row.
    assign row_addr = base_q + d1_acc_q + d2_acc_q;
    assign off      = row_addr[OB-1:0];
    assign misal    = |off;

    // A misaligned row needs one extra beat, so the last index is d0_len rather than d0_len-1.
    assign beats_m1  = {1'b0, d0_len_q} - {{CNT{1'b0}}, ~misal};
    assign row_first = (k_q == '0);
    assign row_last  = (k_q == beats_m1);
    assign d1_wrap   = (d1_cnt_q == d1_len_q - CNT_ONE);
    assign d2_wrap   = (d2_cnt_q == d2_len_q - CNT_ONE);

    assign ones      = '1;
    assign head_strb = ones << off;

    always_comb begin
        strb = ones;
        if (misal) begin
            if (row_first) begin
                strb = head_strb;
            end else if (row_last) begin
                strb = ~head_strb;
            end
        end
    end

    assign addr_valid_o = running;
    assign addr_o       = running ? ({row_addr[AW-1:OB], {OB{1'b0}}} + d0_acc_q) : '0;
    assign strb_o       = running ? strb : '0;
    assign first_o      = running & row_first;
    assign last_o       = running & row_last;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            base_q      <= '0;
            d0_stride_q <= '0;
            d1_stride_q <= '0;
            d2_stride_q <= '0;
            d0_len_q    <= '0;
            d1_len_q    <= '0;
            d2_len_q    <= '0;
            k_q         <= '0;
            d1_cnt_q    <= '0;
            d2_cnt_q    <= '0;
            d0_acc_q    <= '0;
            d1_acc_q    <= '0;
            d2_acc_q    <= '0;
        end else if (clear_i) begin
            state_q  <= IDLE;
            k_q      <= '0;
            d1_cnt_q <= '0;
            d2_cnt_q <= '0;
            d0_acc_q <= '0;
            d1_acc_q <= '0;
            d2_acc_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q      <= base_addr_i;
                        d0_stride_q <= d0_stride_i;
                        d1_stride_q <= d1_stride_i;
                        d2_stride_q <= d2_stride_i;
                        d0_len_q    <= d0_len_i;
                        d1_len_q    <= d1_len_i;
                        d2_len_q    <= d2_len_i;
                        k_q         <= '0;
                        d1_cnt_q    <= '0;
                        d2_cnt_q    <= '0;
                        d0_acc_q    <= '0;
                        d1_acc_q    <= '0;
                        d2_acc_q    <= '0;
                        if ((d0_len_i == '0) || (d1_len_i == '0) || (d2_len_i == '0)) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (!row_last) begin
                            k_q      <= k_q + K_ONE;
                            d0_acc_q <= d0_acc_q + d0_stride_q;
                        end else begin
                            k_q      <= '0;
                            d0_acc_q <= '0;
                            if (!d1_wrap) begin
                                d1_cnt_q <= d1_cnt_q + CNT_ONE;
                                d1_acc_q <= d1_acc_q + d1_stride_q;
                            end else begin
                                d1_cnt_q <= '0;
                                d1_acc_q <= '0;
                                if (!d2_wrap) begin
                                    d2_cnt_q <= d2_cnt_q + CNT_ONE;
                                    d2_acc_q <= d2_acc_q + d2_stride_q;
                                end else begin
                                    d2_cnt_q <= '0;
                                    d2_acc_q <= '0;
                                    state_q  <= DONE;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hwpe_stream_addressgen_v3.sv
// tb/tb_hwpe_stream_addressgen_v3.sv - scoreboard bench for the three-level address generator
module tb_hwpe_stream_addressgen_v3;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic        first;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = '0, s0 = '0, s1 = '0, s2 = '0;
    logic [15:0] l0 = '0, l1 = '0, l2 = '0;
    logic        valid, ready = 1'b1;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic        first, last, busy, done;

    beat_t sb[$];
    beat_t cur, exp_b, hold;
    bit    hold_v = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    done_count = 0;

    hwpe_stream_addressgen_v3 #(.AW(32), .NB_BYTES(4), .CNT(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .start_i      (start),
        .base_addr_i  (base),
        .d0_stride_i  (s0),
        .d0_len_i     (l0),
        .d1_stride_i  (s1),
        .d1_len_i     (l1),
        .d2_stride_i  (s2),
        .d2_len_i     (l2),
        .addr_valid_o (valid),
        .addr_ready_i (ready),
        .addr_o       (addr),
        .strb_o       (strb),
        .first_o      (first),
        .last_o       (last),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every handshake against the scoreboard and checks stability while stalled.
    always @(negedge clk) begin
        if (!rst_n || clear) begin
            hold_v = 1'b0;
        end else begin
            if (done) done_count++;
            if (valid) begin
                cur = '{addr, strb, first, last};
                if (hold_v) chk("stall_hold", 64'(cur), 64'(hold));
                if (ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h expected=none", cur);
                    end else begin
                        exp_b = sb.pop_front();
                        chk("beat", 64'(cur), 64'(exp_b));
                    end
                    hold_v = 1'b0;
                end else begin
                    hold   = cur;
                    hold_v = 1'b1;
                end
            end else begin
                if (hold_v) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_dropped actual=0 expected=1");
                end
                hold_v = 1'b0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] s, input logic f, input logic l);
        sb.push_back('{a, s, f, l});
    endtask

    task automatic start_cfg(input logic [31:0] b, input logic [31:0] st0, input logic [15:0] ln0,
                             input logic [31:0] st1, input logic [15:0] ln1,
                             input logic [31:0] st2, input logic [15:0] ln2);
        base = b; s0 = st0; l0 = ln0; s1 = st1; l1 = ln1; s2 = st2; l2 = ln2;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        base = 32'hDEAD_BEEF; s0 = 32'h0000_0777; s1 = 32'h1234_5678; s2 = 32'h0BAD_F00D;
        l0 = 16'd9; l1 = 16'd0; l2 = 16'd3;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 300) begin
            cycles(1);
            n++;
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk({name, "_busy_in_done"}, 64'(busy), 64'd1);
        chk({name, "_valid_in_done"}, 64'(valid), 64'd0);
        cycles(1);
        chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic push_aligned();
        push(32'h100, 4'hF, 1, 0); push(32'h104, 4'hF, 0, 0);
        push(32'h108, 4'hF, 0, 0); push(32'h10C, 4'hF, 0, 1);
        push(32'h140, 4'hF, 1, 0); push(32'h144, 4'hF, 0, 0);
        push(32'h148, 4'hF, 0, 0); push(32'h14C, 4'hF, 0, 1);
    endtask

    initial begin
        int d;
        int n;
        cycles(2);
        chk("reset_outputs", 64'({valid, addr, strb, first, last, busy, done}), 64'd0);
        rst_n = 1'b1;
        cycles(1);
        chk("idle_busy", 64'(busy), 64'd0);

        push_aligned();
        start_cfg(32'h100, 32'd4, 16'd4, 32'h40, 16'd2, 32'd0, 16'd1);
        wait_done("aligned");

        push(32'h100, 4'hC, 1, 0); push(32'h104, 4'hF, 0, 0); push(32'h108, 4'h3, 0, 1);
        start_cfg(32'h102, 32'd4, 16'd2, 32'd0, 16'd1, 32'd0, 16'd1);
        wait_done("misaligned");

        push(32'h200, 4'hF, 1, 1); push(32'h220, 4'hE, 1, 0); push(32'h224, 4'h1, 0, 1);
        push(32'h300, 4'hF, 1, 1); push(32'h320, 4'hE, 1, 0); push(32'h324, 4'h1, 0, 1);
        start_cfg(32'h200, 32'd4, 16'd1, 32'h21, 16'd2, 32'h100, 16'd2);
        wait_done("per_row_3d");

        push(32'h8, 4'hF, 1, 1); push(32'hFFFF_FFF8, 4'hF, 1, 1);
        start_cfg(32'h8, 32'd4, 16'd1, 32'hFFFF_FFF0, 16'd2, 32'd0, 16'd1);
        wait_done("neg_stride");

        ready = 1'b0;
        push_aligned();
        start_cfg(32'h100, 32'd4, 16'd4, 32'h40, 16'd2, 32'd0, 16'd1);
        for (int b = 0; b < 8; b++) begin
            n = 0;
            while (!valid && n < 50) begin
                cycles(1);
                n++;
            end
            if (b == 2) cycles(3);
            ready = 1'b1;
            cycles(1);
            ready = 1'b0;
        end
        ready = 1'b1;
        wait_done("backpressure");

        start_cfg(32'h100, 32'd4, 16'd4, 32'h40, 16'd0, 32'd0, 16'd1);
        chk("zero_len_valid", 64'(valid), 64'd0);
        wait_done("zero_len");

        push_aligned();
        start_cfg(32'h100, 32'd4, 16'd4, 32'h40, 16'd2, 32'd0, 16'd1);
        cycles(1);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        chk("clear_outputs", 64'({valid, addr, strb, first, last, busy}), 64'd0);
        chk("clear_consumed", 64'(sb.size()), 64'd7);
        sb.delete();
        d = done_count;
        cycles(3);
        chk("clear_no_done", 64'(done_count), 64'(d));
        push_aligned();
        start_cfg(32'h100, 32'd4, 16'd4, 32'h40, 16'd2, 32'd0, 16'd1);
        wait_done("after_clear");

        push_aligned();
        start_cfg(32'h100, 32'd4, 16'd4, 32'h40, 16'd2, 32'd0, 16'd1);
        cycles(2);
        rst_n = 1'b0;
        #1;
        chk("reset_midrun", 64'({valid, addr, strb, first, last, busy, done}), 64'd0);
        sb.delete();
        cycles(1);
        rst_n = 1'b1;
        cycles(1);
        push(32'h100, 4'hC, 1, 0); push(32'h104, 4'hF, 0, 0); push(32'h108, 4'h3, 0, 1);
        start_cfg(32'h102, 32'd4, 16'd2, 32'd0, 16'd1, 32'd0, 16'd1);
        wait_done("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
